// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl -- single-byte I2C write master fed from an upstream FIFO.
//
// Each FIFO entry {addr[6:0], data[7:0]} becomes one frame:
//   START, 7-bit address + W, ACK slot, 8 data bits, ACK slot, STOP.
// Every bit slot is four divider ticks (q0..q3); SCL is low in q0-q1 and
// high in q2-q3, and SDA only changes on entry to q0.
//
// Optional feature macro: I2C_MASTER_ACK_CHECK_EN
//   defined   : a NACK ends the frame early with STOP and raises ack_err_out
//               together with done_out.
//   undefined : ACK slots are timed but sda_in is ignored; ack_err_out is 0.
//
// Parameters:
//   FIFO_WIDTH : width of one FIFO entry (address in [14:8], data in [7:0])
//   CLK_DIV    : i2c_clock_in cycles per SCL quarter-period (2..65535)
//
// Ports:
//   i2c_clock_in   : clock, all logic on the rising edge
//   i2c_reset_in   : synchronous active-high reset
//   fifo_empty_in  : upstream FIFO empty flag
//   fifo_rd_en_out : one-cycle read strobe to the FIFO
//   fifo_data_in   : FIFO entry, valid the cycle after the strobe
//   scl_out        : SCL level (push-pull)
//   sda_out        : SDA level while sda_oe_out=1, else 0
//   sda_oe_out     : SDA output enable (0 = released)
//   sda_in         : sampled SDA for ACK detection
//   busy_out       : high whenever the controller is not idle
//   done_out       : one-cycle pulse when a frame finishes
//   ack_err_out    : NACK seen in the frame; valid only with done_out
module i2c_master_ctrl #(
  parameter int unsigned FIFO_WIDTH = 15,
  parameter int unsigned CLK_DIV    = 125
) (
  input  logic                  i2c_clock_in,
  input  logic                  i2c_reset_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_rd_en_out,
  input  logic [FIFO_WIDTH-1:0] fifo_data_in,
  output logic                  scl_out,
  output logic                  sda_out,
  output logic                  sda_oe_out,
  input  logic                  sda_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  ack_err_out
);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state, n_state;
  logic [1:0]  qtr, n_qtr;
  logic [2:0]  bit_cnt, n_bit_cnt;
  logic [15:0] shreg, n_shreg;
  logic [15:0] div_cnt, n_div_cnt;
  logic        n_rd_en, n_done;
  logic        n_scl, n_sda, n_oe;
  logic        in_frame, tick;

`ifdef I2C_MASTER_ACK_CHECK_EN
  logic        nack, n_nack;
  logic        err, n_err;
`else
  logic        unused_sda_in;
  assign unused_sda_in = sda_in;
  assign ack_err_out   = 1'b0;
`endif

  assign in_frame = (state inside {START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP});
  assign tick     = in_frame && (div_cnt == DIV_LAST);

  // Next-state logic. The shift register is moved left at the end of every
  // address bit, so after the eight address slots its top byte holds the
  // data byte and DATA can keep sending shreg[15].
  always_comb begin
    n_state   = state;
    n_qtr     = qtr;
    n_bit_cnt = bit_cnt;
    n_shreg   = shreg;
    n_rd_en   = 1'b0;
    n_done    = 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
    n_nack    = nack;
    n_err     = err;
`endif
    // Divider only runs inside a frame, so it is at 0 on entry to START.
    n_div_cnt = (in_frame && !tick) ? div_cnt + 16'd1 : '0;

    case (state)
      IDLE: begin
        if (!fifo_empty_in) begin
          n_state = FETCH;
          n_rd_en = 1'b1;
        end
      end
      FETCH: n_state = LOAD;
      LOAD: begin
        n_state = START;
        n_qtr   = 2'd0;
        n_shreg = {fifo_data_in[14:8], 1'b0, fifo_data_in[7:0]};
`ifdef I2C_MASTER_ACK_CHECK_EN
        n_err   = 1'b0;
        n_nack  = 1'b0;
`endif
      end
      default: begin
        if (tick) begin
          if (qtr != 2'd3) begin
            n_qtr = qtr + 2'd1;
`ifdef I2C_MASTER_ACK_CHECK_EN
            // ACK is sampled on the tick that ends q2 (SCL high).
            if (qtr == 2'd2 && (state == ADDR_ACK || state == DATA_ACK))
              n_nack = sda_in;
`endif
          end else begin
            n_qtr = 2'd0;
            case (state)
              START: begin
                n_state   = ADDR;
                n_bit_cnt = 3'd7;
              end
              ADDR: begin
                n_shreg = {shreg[14:0], 1'b0};
                if (bit_cnt == 3'd0) n_state = ADDR_ACK;
                else                 n_bit_cnt = bit_cnt - 3'd1;
              end
              ADDR_ACK: begin
                n_state   = DATA;
                n_bit_cnt = 3'd7;
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (nack) begin
                  n_state = STOP;
                  n_err   = 1'b1;
                end
`endif
              end
              DATA: begin
                n_shreg = {shreg[14:0], 1'b0};
                if (bit_cnt == 3'd0) n_state = DATA_ACK;
                else                 n_bit_cnt = bit_cnt - 3'd1;
              end
              DATA_ACK: begin
                n_state = STOP;
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (nack) n_err = 1'b1;
`endif
              end
              STOP: begin
                n_state = IDLE;
                n_done  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Bus levels derived from the next state/quarter so they are registered
  // alongside the state and change exactly on quarter boundaries.
  always_comb begin
    n_scl = 1'b1;
    n_sda = 1'b0;
    n_oe  = 1'b0;
    case (n_state)
      START: begin
        n_oe  = 1'b1;
        n_sda = ~n_qtr[1];
      end
      ADDR, DATA: begin
        n_oe  = 1'b1;
        n_scl = n_qtr[1];
        n_sda = n_shreg[15];
      end
      ADDR_ACK, DATA_ACK: n_scl = n_qtr[1];
      STOP: begin
        n_oe  = 1'b1;
        n_scl = (n_qtr != 2'd0);
        n_sda = n_qtr[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i2c_clock_in) begin
    if (i2c_reset_in) begin
      state          <= IDLE;
      qtr            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      div_cnt        <= '0;
      fifo_rd_en_out <= 1'b0;
      scl_out        <= 1'b1;
      sda_out        <= 1'b1;
      sda_oe_out     <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack           <= 1'b0;
      err            <= 1'b0;
      ack_err_out    <= 1'b0;
`endif
    end else begin
      state          <= n_state;
      qtr            <= n_qtr;
      bit_cnt        <= n_bit_cnt;
      shreg          <= n_shreg;
      div_cnt        <= n_div_cnt;
      fifo_rd_en_out <= n_rd_en;
      scl_out        <= n_scl;
      sda_out        <= n_sda;
      sda_oe_out     <= n_oe;
      busy_out       <= (n_state != IDLE);
      done_out       <= n_done;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack           <= n_nack;
      err            <= n_err;
      ack_err_out    <= n_done & n_err;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench for i2c_master_ctrl (CLK_DIV=4). A FIFO model and an I2C slave
// model drive the DUT; issued frames push their expected bus behaviour into
// a scoreboard that a negedge monitor checks whenever done_out pulses.
module tb_i2c_master_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int SLOT_CYC = 4 * CLK_DIV;
`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [14:0] fifo_data;
  logic        scl, sda, sda_oe;
  logic        sda_in;
  logic        busy, done, ack_err;

  i2c_master_ctrl #(.FIFO_WIDTH(15), .CLK_DIV(CLK_DIV)) dut (
    .i2c_clock_in   (clk),
    .i2c_reset_in   (rst),
    .fifo_empty_in  (fifo_empty),
    .fifo_rd_en_out (fifo_rd_en),
    .fifo_data_in   (fifo_data),
    .scl_out        (scl),
    .sda_out        (sda),
    .sda_oe_out     (sda_oe),
    .sda_in         (sda_in),
    .busy_out       (busy),
    .done_out       (done),
    .ack_err_out    (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] bits;      // driven SDA bits at SCL rises, oldest in MSB
    int          nbits;
    int          ack_slots; // SCL rises while SDA released
    logic        err;
    int          latency;   // cycles from read strobe to done pulse
  } exp_t;

  typedef struct {
    logic na;
    logic nd;
  } slv_t;

  exp_t        sb_q[$];
  slv_t        slv_q[$];
  logic [14:0] fifo_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is START, 8 address slots, ACK, 8 data slots, ACK,
  // STOP = 20 slots; an address NACK with checking enabled truncates it to
  // START, 8 address slots, ACK, STOP = 11 slots. STOP has one driven SCL rise
  // (SDA low). Two cycles separate the strobe from START.
  function automatic exp_t model(input logic [6:0] a, input logic [7:0] d,
                                 input logic na, input logic nd);
    exp_t e;
    if (ACK_CHECK && na) begin
      e.bits      = {8'd0, a, 1'b0, 1'b0};
      e.nbits     = 9;
      e.ack_slots = 1;
      e.err       = 1'b1;
      e.latency   = 2 + 11 * SLOT_CYC;
    end else begin
      e.bits      = {a, 1'b0, d, 1'b0};
      e.nbits     = 17;
      e.ack_slots = 2;
      e.err       = ACK_CHECK && nd;
      e.latency   = 2 + 20 * SLOT_CYC;
    end
    return e;
  endfunction

  task automatic issue(input logic [6:0] a, input logic [7:0] d,
                       input logic na, input logic nd);
    slv_t s;
    s.na = na;
    s.nd = nd;
    fifo_q.push_back({a, d});
    slv_q.push_back(s);
    sb_q.push_back(model(a, d, na, nd));
  endtask

  // FIFO and slave model, updated just after each rising edge.
  logic rd_pend = 1'b0;
  logic prev_oe = 1'b0;
  logic cur_ack = 1'b1;
  int   ack_idx = 0;
  slv_t cur_slv = '{1'b0, 1'b0};

  always begin
    @(posedge clk);
    #1;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    if (fifo_rd_en) begin
      rd_pend = 1'b1;
      ack_idx = 0;
      if (slv_q.size() > 0) cur_slv = slv_q.pop_front();
    end
    if (prev_oe && !sda_oe && busy) begin
      cur_ack = (ack_idx == 0) ? cur_slv.na : cur_slv.nd;
      ack_idx++;
    end
    prev_oe    = sda_oe;
    sda_in     = sda_oe ? sda : (busy ? cur_ack : 1'b1);
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor / scoreboard checker.
  int          cyc = 0;
  int          last_rd = 0;
  int          done_seen = 0;
  logic [16:0] cap = '0;
  int          nbits = 0, nacks = 0, nstart = 0, nstop = 0;
  logic        p_scl = 1'b1, p_sda = 1'b1, p_oe = 1'b0;
  logic        exp_rd_next = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cap = '0; nbits = 0; nacks = 0; nstart = 0; nstop = 0;
      exp_rd_next = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        last_rd = cyc;
      end
      if (exp_rd_next) check("back_to_back_rd_en", 32'(fifo_rd_en), 32'd1);
      exp_rd_next = 1'b0;
      if (busy && !sda_oe) check("sda_low_when_released", 32'(sda), 32'd0);
      if (!done) check("ack_err_outside_done", 32'(ack_err), 32'd0);

      if (scl && !p_scl) begin
        if (sda_oe) begin
          cap = {cap[15:0], sda};
          nbits++;
        end else begin
          nacks++;
        end
      end
      if (scl && p_scl && sda_oe && p_oe) begin
        if (p_sda && !sda) nstart++;
        if (!p_sda && sda) nstop++;
      end

      if (done) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done_out=1 expected no frame (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_err", 32'(ack_err), 32'(mon_e.err));
          check("done_latency", 32'(cyc - last_rd), 32'(mon_e.latency));
          check("driven_bit_count", 32'(nbits), 32'(mon_e.nbits));
          check("sda_bits", 32'(cap), 32'(mon_e.bits));
          check("ack_slots", 32'(nacks), 32'(mon_e.ack_slots));
          check("start_count", 32'(nstart), 32'd1);
          check("stop_count", 32'(nstop), 32'd1);
        end
        exp_rd_next = !fifo_empty;
        cap = '0; nbits = 0; nacks = 0; nstart = 0; nstop = 0;
      end
    end
    p_scl = scl;
    p_sda = sda;
    p_oe  = sda_oe;
  end

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((sb_q.size() > 0 || fifo_q.size() > 0) && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 20000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", sb_q.size());
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic abort_test();
    slv_t s;
    int   budget;
    int   d0;
    s.na = 1'b0;
    s.nd = 1'b0;
    fifo_q.push_back({7'h33, 8'hC6});
    slv_q.push_back(s);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!fifo_rd_en && budget < 100);
    check("abort_rd_en_seen", 32'(fifo_rd_en), 32'd1);
    // Data bit 3 is slot 14 of the frame: cycles rd+226 .. rd+241.
    repeat (232) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    check("oe_before_abort", 32'(sda_oe), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_sda_oe", 32'(sda_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    d0 = done_seen;
    repeat (400) @(posedge clk);
    #2;
    check("no_done_after_abort", 32'(done_seen), 32'(d0));
    check("abort_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    rst       = 1'b1;
    sda_in    = 1'b1;
    fifo_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_scl", 32'(scl), 32'd1);
    check("reset_sda", 32'(sda), 32'd1);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ack_err", 32'(ack_err), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed: ACK both, NACK address, NACK data.
    issue(7'h2A, 8'h5C, 1'b0, 1'b0);
    wait_drain();
    issue(7'h2A, 8'h5C, 1'b1, 1'b0);
    wait_drain();
    issue(7'h15, 8'hA3, 1'b0, 1'b1);
    wait_drain();
    // Two entries queued together.
    issue(7'h7F, 8'h00, 1'b0, 1'b0);
    issue(7'h00, 8'hFF, 1'b0, 1'b0);
    wait_drain();

    // Random frames, sometimes queued back-to-back.
    for (int i = 0; i < 14; i++) begin
      a = 7'($urandom);
      d = 8'($urandom);
      issue(a, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 400)) @(posedge clk);
        #2;
      end
    end
    wait_drain();

    abort_test();

    issue(7'h2A, 8'h5C, 1'b0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 15, width of one FIFO entry (7-bit address in [14:8], 8-bit data in [7:0]).
REQ-002 SHALL have parameter CLK_DIV, default 125, number of i2c_clock_in cycles per SCL quarter-period; legal range 2..65535.
REQ-003 SHALL have port i2c_clock_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i2c_reset_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fifo_empty_in  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en_out  output  1  one-cycle read strobe to upstream FIFO.
REQ-007 SHALL have port fifo_data_in  input  FIFO_WIDTH  entry from FIFO, valid the cycle after fifo_rd_en_out.
REQ-008 SHALL have port scl_out  output  1  SCL level (push-pull, no clock stretching).
REQ-009 SHALL have port sda_out  output  1  SDA level driven while sda_oe_out=1.
REQ-010 SHALL have port sda_oe_out  output  1  SDA output enable; 0 = released (bus high).
REQ-011 SHALL have port sda_in  input  1  sampled SDA for ACK detection.
REQ-012 SHALL have ports busy_out, done_out, ack_err_out  output  1 each  frame in progress; frame-complete pulse; NACK flag.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, LOAD, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
REQ-014 IDLE -> FETCH when fifo_empty_in=0; FETCH asserts fifo_rd_en_out for exactly one cycle, never while fifo_empty_in=1.
REQ-015 LOAD SHALL latch fifo_data_in into a shift register {addr[6:0], 1'b0 (write), data[7:0]}, then enter START.
REQ-016 Divider counter SHALL count 0..CLK_DIV-1 and issue a tick at CLK_DIV-1; it restarts at 0 on entry to START.
REQ-017 Each bit slot SHALL last 4 ticks (quarters q0..q3): SCL low in q0-q1, high in q2-q3; SDA changes only at q0 entry.
REQ-018 START: SDA=1,SCL=1 in q0-q1; SDA=0,SCL=1 in q2-q3.
REQ-019 ADDR SHALL send 8 bits MSB first (addr[6]..addr[0], R/W=0); DATA SHALL send data[7]..data[0].
REQ-020 ADDR_ACK/DATA_ACK: sda_oe_out=0; sda_in sampled at the tick ending q2; 1 = NACK.
REQ-021 STOP: q0 SCL=0,SDA=0; q1 SCL=1,SDA=0; q2-q3 SCL=1,SDA=1; then IDLE.
REQ-022 Frame = 80 ticks from START entry to STOP exit; done_out SHALL pulse one cycle on STOP exit; ack_err_out valid only in that cycle.
REQ-023 busy_out SHALL be 1 in every state except IDLE.
REQ-024 Back-to-back: from IDLE with fifo_empty_in=0, FETCH occurs the next cycle (3-cycle gap between frames plus divider restart).
REQ-025 sda_out=0 whenever sda_oe_out=0; sda_oe_out=1 in START, ADDR, DATA, STOP.

Reset
REQ-026 On i2c_reset_in=1 at a clock edge: state=IDLE, divider=0, scl_out=1, sda_out=1, sda_oe_out=0, fifo_rd_en_out=0, busy_out=0, done_out=0, ack_err_out=0.
REQ-027 Reset mid-frame SHALL abort without generating STOP and SHALL not pulse done_out; a latched but unsent entry is discarded.

Configuration
REQ-028 Macro I2C_MASTER_ACK_CHECK_EN defined: NACK in ADDR_ACK or DATA_ACK SHALL skip remaining bits, go to STOP, and set ack_err_out=1 with done_out.
REQ-029 Macro I2C_MASTER_ACK_CHECK_EN undefined: ACK slots timed identically but sda_in ignored; full frame always sent; ack_err_out tied 0.

Verification
REQ-030 CLK_DIV=4, FIFO holds 15'h2A_5C (addr 0x2A, data 0x5C), slave ACKs -> SDA bits 0x54 then 0x5C, done_out pulse 322 cycles after first fifo_rd_en_out, ack_err_out=0.
REQ-031 Same, slave NACKs address, macro defined -> STOP right after ADDR_ACK, done_out with ack_err_out=1, no data bits clocked.
REQ-032 Same NACK, macro undefined -> full 80-tick frame, ack_err_out=0.
REQ-033 Two entries queued -> second fifo_rd_en_out one cycle after first done_out; two START/STOP pairs; fifo_rd_en_out never high while fifo_empty_in=1.
REQ-034 Reset asserted during DATA bit 3 -> next cycle scl_out=1, sda_oe_out=0, busy_out=0, no done_out.
